// File: rtl/vita_rx_packetizer.sv
// vita_rx_packetizer: collects sample lines into a packet buffer, then emits one
// VITA-49 IF-data packet (header, stream id, seconds, ticks, payload) on a 36-bit
// {2'b00, eof, sof, word} stream.
module vita_rx_packetizer #(
   parameter int unsigned BASE    = 0,
   parameter int unsigned MAXCHAN = 1,
   parameter int unsigned BUF_AW  = 9
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clear,
   input  logic                    set_stb,
   input  logic [7:0]              set_addr,
   input  logic [31:0]             set_data,
   input  logic [64+32*MAXCHAN:0]  sample_fifo_i,
   input  logic                    sample_fifo_src_rdy_i,
   output logic                    sample_fifo_dst_rdy_o,
   output logic [35:0]             data_o,
   output logic                    src_rdy_o,
   input  logic                    dst_rdy_i
);

   localparam int unsigned LW        = 65 + 32*MAXCHAN;
   localparam int unsigned CHW       = 32*MAXCHAN;
   localparam int unsigned DEPTH     = 2**BUF_AW;
   localparam int unsigned NW        = BUF_AW + 1;
   localparam logic [1:0]  MAX_NC    = 2'(MAXCHAN - 1);
   localparam logic [7:0]  A_NUMCHAN = 8'(BASE);
   localparam logic [7:0]  A_SPP     = 8'(BASE + 1);
   localparam logic [7:0]  A_SID     = 8'(BASE + 2);

   typedef enum logic [2:0] {
      S_FILL, S_WRITE, S_HDR, S_SID, S_SECS, S_TICS_HI, S_TICS_LO, S_PAYLOAD
   } state_t;

   state_t            state;
   logic [1:0]        numchan_r;
   logic [15:0]       spp_r;
   logic [31:0]       sid_r;
   logic [CHW-1:0]    line_l;
   logic              eob_l;
   logic [63:0]       time_l;
   logic [1:0]        numchan_l;
   logic [15:0]       spp_l;
   logic [31:0]       sid_l;
   logic [15:0]       lines_cnt;
   logic [NW-1:0]     nwords;
   logic [NW-1:0]     rd_ptr;
   logic [1:0]        widx;
   logic [3:0]        pkt_cnt;
   logic [31:0]       mem [DEPTH];

   logic              accept_c;
   logic              adv_c;
   logic [1:0]        numchan_c;
   logic [NW:0]       nw_next_c;
   logic [NW:0]       fill_c;
   logic              close_c;
   logic              eof_c;
   logic [31:0]       wr_word_c;
   logic [31:0]       rd_word_c;
   logic [31:0]       hdr_c;

   // Handshake, packet-close decision and word selection
   assign accept_c  = sample_fifo_dst_rdy_o & sample_fifo_src_rdy_i;
   assign adv_c     = src_rdy_o & dst_rdy_i;
   assign numchan_c = (numchan_r > MAX_NC) ? MAX_NC : numchan_r;
   assign nw_next_c = (NW+1)'(nwords) + (NW+1)'(1);
   assign fill_c    = nw_next_c + (NW+1)'(numchan_l) + (NW+1)'(1);
   assign close_c   = eob_l | (lines_cnt == spp_l) | (fill_c > (NW+1)'(DEPTH));
   assign eof_c     = (NW'(rd_ptr + NW'(1)) == nwords);
   assign wr_word_c = line_l[32*widx +: 32];
   assign rd_word_c = mem[rd_ptr[BUF_AW-1:0]];
   assign hdr_c     = {4'b0001, 3'b000, eob_l, 2'b01, 2'b01, pkt_cnt,
                       16'(nw_next_c + (NW+1)'(5))};

   // Settings registers; survive clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         numchan_r <= 2'd0;
         spp_r     <= 16'd64;
         sid_r     <= 32'd0;
      end else if (set_stb) begin
         if (set_addr == A_NUMCHAN) numchan_r <= set_data[1:0];
         if (set_addr == A_SPP)     spp_r     <= set_data[15:0];
         if (set_addr == A_SID)     sid_r     <= set_data;
      end
   end

   // Payload buffer write, one channel word per WRITE cycle
   always_ff @(posedge clk) begin
      if (state == S_WRITE && !clear) mem[nwords[BUF_AW-1:0]] <= wr_word_c;
   end

   // Packet FSM with registered handshake and data outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state                 <= S_FILL;
         sample_fifo_dst_rdy_o <= 1'b0;
         src_rdy_o             <= 1'b0;
         data_o                <= '0;
         pkt_cnt               <= '0;
         nwords                <= '0;
         lines_cnt             <= '0;
         widx                  <= '0;
         rd_ptr                <= '0;
         line_l                <= '0;
         eob_l                 <= 1'b0;
         time_l                <= '0;
         numchan_l             <= '0;
         spp_l                 <= 16'd1;
         sid_l                 <= '0;
      end else if (clear) begin
         state                 <= S_FILL;
         sample_fifo_dst_rdy_o <= 1'b0;
         src_rdy_o             <= 1'b0;
         data_o                <= '0;
         pkt_cnt               <= '0;
         nwords                <= '0;
         lines_cnt             <= '0;
         widx                  <= '0;
         rd_ptr                <= '0;
      end else begin
         case (state)
            S_FILL: begin
               if (accept_c) begin
                  sample_fifo_dst_rdy_o <= 1'b0;
                  line_l                <= sample_fifo_i[LW-1:65];
                  eob_l                 <= sample_fifo_i[64];
                  lines_cnt             <= lines_cnt + 16'd1;
                  widx                  <= '0;
                  if (lines_cnt == 16'd0) begin
                     time_l    <= sample_fifo_i[63:0];
                     numchan_l <= numchan_c;
                     spp_l     <= (spp_r == 16'd0) ? 16'd1 : spp_r;
                     sid_l     <= sid_r;
                  end
                  state <= S_WRITE;
               end else begin
                  sample_fifo_dst_rdy_o <= 1'b1;
               end
            end
            S_WRITE: begin
               nwords <= NW'(nw_next_c);
               if (widx == numchan_l) begin
                  if (close_c) begin
                     state     <= S_HDR;
                     src_rdy_o <= 1'b1;
                     data_o    <= {4'b0001, hdr_c};
                  end else begin
                     state                 <= S_FILL;
                     sample_fifo_dst_rdy_o <= 1'b1;
                  end
               end else begin
                  widx <= widx + 2'd1;
               end
            end
            S_HDR: if (adv_c) begin
               state  <= S_SID;
               data_o <= {4'b0000, sid_l};
            end
            S_SID: if (adv_c) begin
               state  <= S_SECS;
               data_o <= {4'b0000, time_l[63:32]};
            end
            S_SECS: if (adv_c) begin
               state  <= S_TICS_HI;
               data_o <= '0;
            end
            S_TICS_HI: if (adv_c) begin
               state  <= S_TICS_LO;
               data_o <= {4'b0000, time_l[31:0]};
            end
            S_TICS_LO: if (adv_c) begin
               state  <= S_PAYLOAD;
               data_o <= {2'b00, eof_c, 1'b0, rd_word_c};
               rd_ptr <= NW'(rd_ptr + NW'(1));
            end
            S_PAYLOAD: if (adv_c) begin
               if (data_o[33]) begin
                  state                 <= S_FILL;
                  src_rdy_o             <= 1'b0;
                  data_o                <= '0;
                  pkt_cnt               <= pkt_cnt + 4'd1;
                  nwords                <= '0;
                  lines_cnt             <= '0;
                  rd_ptr                <= '0;
                  sample_fifo_dst_rdy_o <= 1'b1;
               end else begin
                  data_o <= {2'b00, eof_c, 1'b0, rd_word_c};
                  rd_ptr <= NW'(rd_ptr + NW'(1));
               end
            end
            default: state <= S_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_vita_rx_packetizer.sv
// Bench for vita_rx_packetizer: packet-level reference model fed by a line driver,
// output monitor comparing every accepted word and stall stability.
module tb_vita_rx_packetizer;

   localparam int MAXCHAN = 2;
   localparam int BUF_AW  = 3;
   localparam int DEPTH   = 8;
   localparam int LW      = 65 + 32*MAXCHAN;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          clear = 1'b0;
   logic          set_stb = 1'b0;
   logic [7:0]    set_addr = '0;
   logic [31:0]   set_data = '0;
   logic [LW-1:0] sample_fifo_i = '0;
   logic          fifo_src_rdy = 1'b0;
   logic          fifo_dst_rdy;
   logic [35:0]   data_o;
   logic          src_rdy_o;
   logic          dst_rdy_i = 1'b1;
   bit            stall_en = 1'b0;

   int checks = 0;
   int errors = 0;
   int n_words = 0;

   // Reference model state
   int          m_numchan = 0;
   int          m_spp = 64;
   logic [31:0] m_sid = '0;
   int          m_pkt = 0;
   logic [31:0] p_words[$];
   int          p_lines = 0;
   int          p_chans = 1;
   int          p_spp = 1;
   logic [31:0] p_sid = '0;
   logic [63:0] p_time = '0;
   logic [35:0] exp_q[$];

   vita_rx_packetizer #(.BASE(0), .MAXCHAN(MAXCHAN), .BUF_AW(BUF_AW)) dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .clear                 (clear),
      .set_stb               (set_stb),
      .set_addr              (set_addr),
      .set_data              (set_data),
      .sample_fifo_i         (sample_fifo_i),
      .sample_fifo_src_rdy_i (fifo_src_rdy),
      .sample_fifo_dst_rdy_o (fifo_dst_rdy),
      .data_o                (data_o),
      .src_rdy_o             (src_rdy_o),
      .dst_rdy_i             (dst_rdy_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Close the modelled packet: header, sid, secs, tics, payload
   task automatic model_close(input logic eob);
      logic [31:0] hdr;
      int n;
      n   = p_words.size();
      hdr = {4'b0001, 3'b000, eob, 2'b01, 2'b01, 4'(m_pkt), 16'(5 + n)};
      exp_q.push_back({2'b00, 1'b0, 1'b1, hdr});
      exp_q.push_back({4'b0000, p_sid});
      exp_q.push_back({4'b0000, p_time[63:32]});
      exp_q.push_back(36'h0);
      exp_q.push_back({4'b0000, p_time[31:0]});
      for (int i = 0; i < n; i++)
         exp_q.push_back({2'b00, (i == n - 1), 1'b0, p_words[i]});
      m_pkt = (m_pkt + 1) % 16;
      p_words.delete();
      p_lines = 0;
   endtask

   task automatic model_line(input logic [31:0] c0, input logic [31:0] c1,
                             input logic eob, input logic [63:0] t);
      logic [31:0] ch [2];
      ch[0] = c0;
      ch[1] = c1;
      if (p_lines == 0) begin
         p_chans = ((m_numchan > MAXCHAN - 1) ? MAXCHAN - 1 : m_numchan) + 1;
         p_spp   = (m_spp == 0) ? 1 : m_spp;
         p_sid   = m_sid;
         p_time  = t;
      end
      for (int c = 0; c < p_chans; c++) p_words.push_back(ch[c]);
      p_lines++;
      if (eob || p_lines == p_spp || p_words.size() + p_chans > DEPTH) model_close(eob);
   endtask

   task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
      set_stb  = 1'b1;
      set_addr = a;
      set_data = d;
      @(posedge clk); #1;
      set_stb  = 1'b0;
      case (a)
         8'd0:    m_numchan = int'(d[1:0]);
         8'd1:    m_spp = int'(d[15:0]);
         8'd2:    m_sid = d;
         default: ;
      endcase
   endtask

   task automatic send(input logic [31:0] c0, input logic [31:0] c1,
                       input logic eob, input logic [63:0] t);
      int n;
      model_line(c0, c1, eob, t);
      sample_fifo_i = {c1, c0, eob, t};
      fifo_src_rdy  = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fifo_dst_rdy && n < 500);
      check("line_accept", 64'(fifo_dst_rdy), 64'd1);
      @(posedge clk); #1;
      fifo_src_rdy = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || src_rdy_o) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain_q", 64'(exp_q.size()), 64'd0);
      check("drain_src", 64'(src_rdy_o), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      p_words.delete();
      p_lines = 0;
      m_pkt   = 0;
   endtask

   // Downstream ready: always high, or random when stalling is enabled
   initial begin
      forever begin
         @(posedge clk); #1;
         dst_rdy_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // Output monitor: compare accepted words, require stability while stalled
   logic [35:0] prev_data = '0;
   logic        prev_stall = 1'b0;
   always @(negedge clk) begin
      logic [35:0] e;
      if (reset_n) begin
         if (prev_stall) begin
            check("stall_src", 64'(src_rdy_o), 64'd1);
            check("stall_data", 64'(data_o), 64'(prev_data));
         end
         if (src_rdy_o && dst_rdy_i) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 36'hF_FFFF_FFFF;
            check($sformatf("word%0d", n_words), 64'(data_o), 64'(e));
            n_words++;
         end
         prev_stall = src_rdy_o && !dst_rdy_i;
         prev_data  = data_o;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic [63:0] t;
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_src", 64'(src_rdy_o), 64'd0);
      check("rst_data", 64'(data_o), 64'd0);
      check("rst_dst", 64'(fifo_dst_rdy), 64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("post_rst_dst", 64'(fifo_dst_rdy), 64'd1);
      check("post_rst_src", 64'(src_rdy_o), 64'd0);
      @(posedge clk); #1;

      // Single channel, spp=4, time taken from the first line only
      set_reg(8'd0, 32'd0);
      set_reg(8'd1, 32'd4);
      set_reg(8'd2, 32'hA5);
      base = n_words;
      t = 64'h0000_0002_0000_0064;
      send(32'h11, 32'h0, 1'b0, t);
      send(32'h22, 32'h0, 1'b0, t + 64'd10);
      send(32'h33, 32'h0, 1'b0, t + 64'd20);
      send(32'h44, 32'h0, 1'b0, t + 64'd30);
      wait_idle();
      check("t1_words", 64'(n_words - base), 64'd9);

      // Two channels, spp=2, eob closes a short packet
      set_reg(8'd0, 32'd1);
      set_reg(8'd1, 32'd2);
      send(32'hA1, 32'hB1, 1'b0, 64'h100);
      send(32'hA2, 32'hB2, 1'b0, 64'h101);
      send(32'hA3, 32'hB3, 1'b1, 64'h102);
      wait_idle();

      // 20 single-line packets: pkt_cnt wraps
      set_reg(8'd0, 32'd0);
      set_reg(8'd1, 32'd1);
      base = n_words;
      for (int i = 0; i < 20; i++) send(32'(i + 1000), 32'h0, 1'b0, 64'(i * 7));
      wait_idle();
      check("t3_words", 64'(n_words - base), 64'd120);

      // Buffer capacity closes packets on line boundaries
      set_reg(8'd0, 32'd1);
      set_reg(8'd1, 32'd100);
      for (int i = 0; i < 10; i++) send($urandom, $urandom, 1'b0, 64'(i + 500));
      send(32'h5A5A, 32'hA5A5, 1'b1, 64'd999);
      wait_idle();

      // Settings written mid-packet apply to the next packet; spp=0 acts as 1; numchan clamps
      set_reg(8'd1, 32'd3);
      send(32'h1, 32'h2, 1'b0, 64'h7000);
      set_reg(8'd1, 32'd0);
      set_reg(8'd0, 32'd3);
      set_reg(8'd2, 32'hDEAD_BEEF);
      send(32'h3, 32'h4, 1'b0, 64'h7001);
      send(32'h5, 32'h6, 1'b0, 64'h7002);
      send(32'h7, 32'h8, 1'b0, 64'h7003);
      wait_idle();

      // Clear mid-packet: nothing emitted, count restarts, new time used
      set_reg(8'd0, 32'd0);
      set_reg(8'd1, 32'd4);
      send(32'hC1, 32'h0, 1'b0, 64'h1111_0000_2222);
      send(32'hC2, 32'h0, 1'b0, 64'h1111_0000_2223);
      pulse_clear();
      repeat (6) @(posedge clk);
      #1;
      check("clr_src", 64'(src_rdy_o), 64'd0);
      check("clr_data", 64'(data_o), 64'd0);
      for (int i = 0; i < 4; i++) send(32'(i + 32'hD0), 32'h0, 1'b0, 64'(64'h3333_0000 + i));
      wait_idle();

      // Random lines and settings with random downstream stalls
      stall_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 15) == 0) set_reg(8'd0, 32'($urandom_range(0, 3)));
         if ($urandom_range(0, 15) == 0) set_reg(8'd1, 32'($urandom_range(0, 6)));
         if ($urandom_range(0, 15) == 0) set_reg(8'd2, $urandom);
         send($urandom, $urandom, ($urandom_range(0, 7) == 0), {$urandom, $urandom});
      end
      send($urandom, $urandom, 1'b1, {$urandom, $urandom});
      wait_idle();
      stall_en = 1'b0;
      repeat (4) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
